adc_scan_bank: RTL and testbench

- Parametrised, single-clock successor to the fixed 8+4 ADC capture bank.
- A scan FSM steps the external ADC mux address over a runtime channel mask and waits a settle time after each address change.
- It averages 2^AVG_LOG2 samples per channel and stores each result in a per-channel register with a valid flag.
- Supports single-shot and continuous scanning; a combinational read port feeds the display/CPU side.

---
 rtl/adc_scan_bank.sv | 157 +++++++++++++++
 tb/tb_adc_scan_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_bank.sv
// rtl/adc_scan_bank.sv - masked ADC channel scanner with settle delay, sample averaging and result bank
// Steps adc_addr over the latched mask; each channel: settle, accumulate 2^AVG_LOG2 samples, store.
module adc_scan_bank #(
  parameter int DATA_W        = 8,
  parameter int NUM_CH        = 12,
  parameter int ADDR_W        = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int AVG_LOG2      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              valid_clr,
  output logic [ADDR_W-1:0] adc_addr,
  output logic              busy,
  output logic              scan_done,
  input  logic [ADDR_W-1:0] rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_CYCLES > NSAMP) ? SETTLE_CYCLES : NSAMP;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'(NSAMP - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, STORE} state_t;

  state_t            state, state_n;
  logic [NUM_CH-1:0] mask_q, mask_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [ACC_W-1:0]  acc_q, acc_n;
  logic              done_q, done_n;
  logic              store_en;
  logic [DATA_W-1:0] res_q [NUM_CH];
  logic [NUM_CH-1:0] valid_q;

  logic [ADDR_W-1:0] higher_ch, first_ch;
  logic              higher_found;

  // Descending loops leave the lowest qualifying index in the result.
  always_comb begin
    higher_found = 1'b0;
    higher_ch    = '0;
    first_ch     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (ADDR_W'(i) > addr_q)) begin
        higher_found = 1'b1;
        higher_ch    = ADDR_W'(i);
      end
      if (ch_mask[i]) first_ch = ADDR_W'(i);
    end
  end

  always_comb begin
    state_n  = state;
    mask_n   = mask_q;
    addr_n   = addr_q;
    cnt_n    = cnt_q;
    acc_n    = acc_q;
    done_n   = 1'b0;
    store_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (|ch_mask) begin
            mask_n  = ch_mask;
            addr_n  = first_ch;
            cnt_n   = '0;
            state_n = SETTLE;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_n   = '0;
          acc_n   = '0;
          state_n = ACCUM;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ACCUM: begin
        acc_n = acc_q + ACC_W'(adc_data);
        if (cnt_q == ACCUM_LAST) begin
          cnt_n   = '0;
          state_n = STORE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      STORE: begin
        store_en = 1'b1;
        cnt_n    = '0;
        if (higher_found) begin
          addr_n  = higher_ch;
          state_n = SETTLE;
        end else begin
          done_n = 1'b1;
          if (continuous) begin
            mask_n = ch_mask;
            if (|ch_mask) begin
              addr_n  = first_ch;
              state_n = SETTLE;
            end else begin
              state_n = IDLE;
            end
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
    end else begin
      state  <= state_n;
      mask_q <= mask_n;
      addr_q <= addr_n;
      cnt_q  <= cnt_n;
      acc_q  <= acc_n;
      done_q <= done_n;
      // A clear coinciding with a store still leaves the stored channel valid.
      valid_q <= (valid_clr ? '0 : valid_q) | (store_en ? (NUM_CH'(1) << addr_q) : '0);
      if (store_en) res_q[addr_q] <= DATA_W'(acc_q >> AVG_LOG2);
    end
  end

  assign adc_addr  = addr_q;
  assign busy      = (state != IDLE);
  assign scan_done = done_q;

  logic rd_in_range;
  assign rd_in_range = ({1'b0, rd_sel} < (ADDR_W + 1)'(NUM_CH));
  assign rd_data     = rd_in_range ? res_q[rd_sel] : '0;
  assign rd_valid    = rd_in_range ? valid_q[rd_sel] : 1'b0;

endmodule

// File: tb/tb_adc_scan_bank.sv
// tb/tb_adc_scan_bank.sv - scoreboard bench for adc_scan_bank
// Stimulus pushes expected scan_done records; a monitor pops them and probes the read port.
module tb_adc_scan_bank;

  logic        clk;
  logic        reset;
  logic        start;
  logic        continuous;
  logic [11:0] ch_mask;
  logic [7:0]  adc_data;
  logic        valid_clr;
  logic [3:0]  adc_addr;
  logic        busy;
  logic        scan_done;
  logic [3:0]  rd_sel;
  logic [7:0]  rd_data;
  logic        rd_valid;

  logic        use_addr;
  logic [7:0]  const_data;

  assign adc_data = use_addr ? (8'h20 + {4'h0, adc_addr}) : const_data;

  adc_scan_bank #(
    .DATA_W(8), .NUM_CH(12), .ADDR_W(4), .SETTLE_CYCLES(4), .AVG_LOG2(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .adc_data(adc_data), .valid_clr(valid_clr),
    .adc_addr(adc_addr), .busy(busy), .scan_done(scan_done),
    .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [11:0] vis;
    logic [11:0] chk;
    logic [11:0] vmask;
    logic [7:0]  data [12];
  } exp_t;

  exp_t        exp_q [$];
  logic [7:0]  shadow [12];
  int          n_pass = 0;
  int          n_total = 0;
  int          t0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
  endtask

  task automatic push(input int c, input logic [11:0] v, input logic [11:0] ck,
                      input logic [11:0] vm);
    exp_t e;
    e.cyc   = c;
    e.vis   = v;
    e.chk   = ck;
    e.vmask = vm;
    e.data  = shadow;
    exp_q.push_back(e);
  endtask

  task automatic go(input logic [11:0] m);
    ch_mask = m;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic at(input int k);
    while (cyc < t0 + k) @(negedge clk);
  endtask

  // Monitor: compares every scan_done against the next expected record.
  logic [11:0] vis = '0;
  exp_t        got;
  initial begin
    rd_sel = '0;
    forever begin
      @(negedge clk);
      if (scan_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_scan_done", 32'(scan_done), 32'd0);
        end else begin
          got = exp_q.pop_front();
          check("scan_done_cycle", 32'(cyc), 32'(got.cyc));
          check("visited_channels", 32'(vis), 32'(got.vis));
          for (int ch = 0; ch < 12; ch++) begin
            if (got.chk[ch]) begin
              rd_sel = 4'(ch);
              #1;
              check($sformatf("rd_valid ch%0d", ch), 32'(rd_valid), 32'(got.vmask[ch]));
              check($sformatf("rd_data ch%0d", ch), 32'(rd_data), 32'(got.data[ch]));
            end
          end
          rd_sel = 4'd13;
          #1;
          check("rd_data out_of_range", 32'(rd_data), 32'd0);
          check("rd_valid out_of_range", 32'(rd_valid), 32'd0);
        end
        vis = '0;
      end
      if (busy) vis = vis | (12'd1 << adc_addr);
      else vis = '0;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; ch_mask = '0;
    valid_clr = 1'b0; use_addr = 1'b0; const_data = '0;
    for (int i = 0; i < 12; i++) shadow[i] = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset adc_addr", 32'(adc_addr), 32'd0);
    check("reset scan_done", 32'(scan_done), 32'd0);
    reset = 1'b0;

    // Single-channel shot on channel 0.
    const_data = 8'h5A;
    go(12'h001);
    shadow[0] = 8'h5A;
    push(t0 + 10, 12'h001, 12'hFFF, 12'h001);
    for (int k = 1; k <= 10; k++) begin
      at(k);
      check($sformatf("shot busy c%0d", k), 32'(busy), 32'(k <= 9));
      check($sformatf("shot adc_addr c%0d", k), 32'(adc_addr), 32'd0);
    end
    at(12);

    // Truncating average on channel 3: 0x10+0x11*3 = 0x43, >>2 = 0x10.
    const_data = 8'h10;
    go(12'h008);
    shadow[3] = 8'h10;
    push(t0 + 10, 12'h008, 12'h009, 12'h009);
    at(6);
    const_data = 8'h11;
    at(12);

    // Masked sequence 0, 2, 11.
    use_addr = 1'b1;
    go(12'h805);
    shadow[0] = 8'h20; shadow[2] = 8'h22; shadow[11] = 8'h2B;
    push(t0 + 28, 12'h805, 12'h80F, 12'h80D);
    at(30);

    // Continuous wrap, mask change mid-scan, then stop.
    continuous = 1'b1;
    go(12'h003);
    shadow[1] = 8'h21;
    push(t0 + 19, 12'h003, 12'h007, 12'h007);
    push(t0 + 37, 12'h003, 12'h007, 12'h007);
    push(t0 + 55, 12'h003, 12'h007, 12'h007);
    push(t0 + 64, 12'h004, 12'h007, 12'h007);
    push(t0 + 73, 12'h004, 12'h007, 12'h007);
    at(40);
    ch_mask = 12'h004;
    at(66);
    continuous = 1'b0;
    at(74);
    check("cont stop busy c74", 32'(busy), 32'd0);
    at(80);
    check("cont stop busy c80", 32'(busy), 32'd0);

    // Start with empty mask.
    use_addr = 1'b0;
    go(12'h000);
    push(t0 + 1, 12'h000, 12'h000, 12'h000);
    at(1);
    check("empty busy c1", 32'(busy), 32'd0);
    at(2);
    check("empty busy c2", 32'(busy), 32'd0);
    at(4);

    // Start while busy ignored; valid_clr in the STORE cycle.
    const_data = 8'h77;
    go(12'h010);
    shadow[4] = 8'h77;
    push(t0 + 10, 12'h010, 12'h81F, 12'h010);
    at(3);
    ch_mask = 12'h001;
    start = 1'b1;
    at(4);
    start = 1'b0;
    ch_mask = 12'h010;
    at(9);
    valid_clr = 1'b1;
    at(10);
    valid_clr = 1'b0;
    check("busy after store c10", 32'(busy), 32'd0);
    at(12);
    check("busy after store c12", 32'(busy), 32'd0);

    // Reset during ACCUM on channel 8.
    const_data = 8'h33;
    go(12'h100);
    at(6);
    reset = 1'b1;
    at(7);
    reset = 1'b0;
    check("post reset busy", 32'(busy), 32'd0);
    check("post reset adc_addr", 32'(adc_addr), 32'd0);
    check("post reset scan_done", 32'(scan_done), 32'd0);
    at(14);
    for (int i = 0; i < 12; i++) shadow[i] = '0;

    // Normal scan after reset: only channel 1 valid, all other data cleared.
    const_data = 8'h44;
    go(12'h002);
    shadow[1] = 8'h44;
    push(t0 + 10, 12'h002, 12'hFFF, 12'h002);
    at(14);

    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("missing_scan_done", 32'(cyc), 32'(got.cyc));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
